// File: rtl/serial_tx.sv
// Asynchronous-style UART-like transmitter: one start bit, DATA_W data bits LSB first,
// one stop bit, each bit held CLKS_PER_BIT clocks on a registered TX line.
module serial_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] DIN,
   input  logic              DIN_VALID,
   output logic              DIN_READY,
   output logic              TX,
   output logic              BUSY,
   output logic              DONE
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state;
   state_t            state_nx;
   logic [CW-1:0]     cnt;
   logic [BW-1:0]     bitcnt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shreg_sh;
   logic              wrap;
   logic              tx_nx;
   logic              done_nx;

   assign wrap      = (cnt == CNT_LAST);
   assign shreg_sh  = shreg >> 1;
   assign DIN_READY = (state == IDLE);
   assign BUSY      = (state != IDLE);

   // TX is precomputed for the next state so the line itself is always a flop output
   always_comb begin
      state_nx = state;
      tx_nx    = TX;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            tx_nx = 1'b1;
            if (DIN_VALID) begin
               state_nx = START;
               tx_nx    = 1'b0;
            end
         end
         START: begin
            if (wrap) begin
               state_nx = DATA;
               tx_nx    = shreg[0];
            end
         end
         DATA: begin
            if (wrap) begin
               if (bitcnt == BIT_LAST) begin
                  state_nx = STOP;
                  tx_nx    = 1'b1;
               end else begin
                  tx_nx = shreg_sh[0];
               end
            end
         end
         STOP: begin
            if (wrap) begin
               state_nx = IDLE;
               tx_nx    = 1'b1;
               done_nx  = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            tx_nx    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state  <= IDLE;
         TX     <= 1'b1;
         DONE   <= 1'b0;
         cnt    <= '0;
         bitcnt <= '0;
         shreg  <= '0;
      end else begin
         state <= state_nx;
         TX    <= tx_nx;
         DONE  <= done_nx;
         if (state == IDLE) begin
            cnt    <= '0;
            bitcnt <= '0;
            if (DIN_VALID)
               shreg <= DIN;
         end else begin
            cnt <= wrap ? '0 : cnt + CW'(1);
            if (state == DATA && wrap) begin
               shreg  <= shreg_sh;
               bitcnt <= (bitcnt == BIT_LAST) ? '0 : bitcnt + BW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: a default instance (8 bits, 4 clocks/bit) and a 1 clock/bit instance,
// driven from a vector table, random words and a mid-frame reset sequence.
module tb_serial_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din_a, din_b;
   logic       valid_a, valid_b;
   logic       rdy_a, tx_a, busy_a, done_a;
   logic       rdy_b, tx_b, busy_b, done_b;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_done [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
      .CLK(clk), .RESET(rst), .DIN(din_a), .DIN_VALID(valid_a),
      .DIN_READY(rdy_a), .TX(tx_a), .BUSY(busy_a), .DONE(done_a));

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut_b (
      .CLK(clk), .RESET(rst), .DIN(din_b), .DIN_VALID(valid_b),
      .DIN_READY(rdy_b), .TX(tx_b), .BUSY(busy_b), .DONE(done_b));

   typedef struct {
      int         which;
      logic [7:0] din;
      logic [9:0] exp;      // line bits in send order, MSB first
      bit         disturb;
      bit         hold;
   } vec_t;

   vec_t tbl [7];

   // Frame as it should appear on the line: start 0, data LSB first, stop 1
   function automatic logic [9:0] model_frame(input logic [7:0] d);
      logic [9:0] f;
      f[9] = 1'b0;
      for (int p = 0; p < 8; p++) f[8-p] = d[p];
      f[0] = 1'b1;
      return f;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic get(input int which, output logic tx, output logic rdy,
                      output logic busy, output logic done);
      if (which == 0) begin tx = tx_a; rdy = rdy_a; busy = busy_a; done = done_a; end
      else            begin tx = tx_b; rdy = rdy_b; busy = busy_b; done = done_b; end
   endtask

   task automatic drive(input int which, input logic [7:0] d, input logic v);
      if (which == 0) begin din_a = d; valid_a = v; end
      else            begin din_b = d; valid_b = v; end
   endtask

   task automatic set_valid(input int which, input logic v);
      if (which == 0) valid_a = v;
      else            valid_b = v;
   endtask

   // Entered and left #1 after a rising edge; the word is accepted on the next edge
   task automatic frame(input int which, input logic [7:0] din, input logic [9:0] exp,
                        input bit disturb, input bit hold);
      int   cpb = (which == 0) ? 4 : 1;
      logic tx, rdy, busy, done;
      get(which, tx, rdy, busy, done);
      chk("ready_before_accept", {31'd0, rdy}, 32'd1);
      drive(which, din, 1'b1);
      @(posedge clk); #1;
      if (!hold) set_valid(which, 1'b0);
      for (int j = 0; j < 10*cpb; j++) begin
         get(which, tx, rdy, busy, done);
         chk("tx_bit", {31'd0, tx}, {31'd0, exp[9 - j/cpb]});
         chk("busy_in_frame", {29'd0, rdy, busy, done}, 32'b010);
         if (disturb && j == 3*cpb) drive(which, ~din, 1'b1);
         if (disturb && j == 3*cpb + 1 && !hold) set_valid(which, 1'b0);
         @(posedge clk); #1;
      end
      get(which, tx, rdy, busy, done);
      chk("done_cycle", {28'd0, done, rdy, busy, tx}, 32'b1101);
      if (last_done[which] >= 0)
         chk("done_spacing", cyc - last_done[which], 10*cpb + 1);
      last_done[which] = cyc;
   endtask

   initial begin
      logic       tx, rdy, busy, done;
      logic [7:0] d;
      int         prev_which;

      last_done[0] = -1;
      last_done[1] = -1;
      rst = 1'b1;
      drive(0, 8'h00, 1'b0);
      drive(1, 8'h00, 1'b0);

      tbl[0] = '{0, 8'hA5, 10'b0101001011, 1'b0, 1'b0};
      tbl[1] = '{0, 8'h00, 10'b0000000001, 1'b0, 1'b0};
      tbl[2] = '{0, 8'hFF, 10'b0111111111, 1'b0, 1'b0};
      tbl[3] = '{0, 8'h3C, 10'b0001111001, 1'b0, 1'b1};
      tbl[4] = '{0, 8'hC3, 10'b0110000111, 1'b0, 1'b0};
      tbl[5] = '{0, 8'h96, 10'b0011010011, 1'b1, 1'b0};
      tbl[6] = '{1, 8'h81, 10'b0100000011, 1'b0, 1'b0};

      #1;
      for (int w = 0; w < 2; w++) begin
         get(w, tx, rdy, busy, done);
         chk("reset_state", {28'd0, done, rdy, busy, tx}, 32'b0101);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      prev_which = 0;
      for (int i = 0; i < 7; i++) begin
         if (tbl[i].which != prev_which) last_done[tbl[i].which] = -1;
         prev_which = tbl[i].which;
         frame(tbl[i].which, tbl[i].din, tbl[i].exp, tbl[i].disturb, tbl[i].hold);
      end

      last_done[0] = -1;
      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom_range(0, 255));
         frame(0, d, model_frame(d), (i % 2) == 1, (i % 3) == 0 && i != 5);
      end
      last_done[1] = -1;
      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom_range(0, 255));
         frame(1, d, model_frame(d), (i % 2) == 0, 1'b0);
      end

      // Reset in the middle of the data bits of a frame on the default instance
      drive(0, 8'h5A, 1'b1);
      @(posedge clk); #1;
      valid_a = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      chk("busy_before_reset", {31'd0, busy_a}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("reset_abort", {28'd0, done_a, rdy_a, busy_a, tx_a}, 32'b0101);
      @(posedge clk); #1;
      chk("reset_held", {28'd0, done_a, rdy_a, busy_a, tx_a}, 32'b0101);
      @(negedge clk) rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("no_done_after_abort", {29'd0, done_a, rdy_a, tx_a}, 32'b011);
      end
      last_done[0] = -1;
      frame(0, 8'h5A, model_frame(8'h5A), 1'b0, 1'b0);
      d = 8'($urandom_range(0, 255));
      frame(0, d, model_frame(d), 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the number of data bits per frame (legal range 1..16).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, the number of CLK cycles each serial bit is held (legal range 1..1024).
REQ-003 SHALL have port CLK, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port RESET, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port DIN, input, DATA_W bits, the parallel word to transmit.
REQ-006 SHALL have port DIN_VALID, input, 1 bit; high means DIN holds a word to send.
REQ-007 SHALL have port DIN_READY, output, 1 bit; high means a word can be accepted this cycle.
REQ-008 SHALL have port TX, output, 1 bit, the registered serial line, idle high.
REQ-009 SHALL have port BUSY, output, 1 bit; high while a frame is in progress.
REQ-010 SHALL have port DONE, output, 1 bit, a one-cycle pulse when a frame completes.

Function
REQ-011 SHALL implement four states: IDLE, START, DATA, STOP.
REQ-012 SHALL drive DIN_READY=1 only in IDLE; BUSY SHALL be the exact complement of DIN_READY.
REQ-013 SHALL accept a word on a rising edge where DIN_VALID=1 and DIN_READY=1, latching DIN into an internal shift register and moving IDLE->START.
REQ-014 SHALL ignore DIN and DIN_VALID in every state other than IDLE; changes to DIN mid-frame SHALL NOT alter the frame.
REQ-015 SHALL drive TX=1 in IDLE, TX=0 in START, TX=current data bit in DATA, and TX=1 in STOP; all TX values come from a flop, with no combinational path from DIN.
REQ-016 SHALL hold each bit on TX for exactly CLKS_PER_BIT cycles, using a cycle counter that counts 0..CLKS_PER_BIT-1 and wraps to 0.
REQ-017 SHALL transmit data bits LSB first, bit 0 through bit DATA_W-1, using a bit counter 0..DATA_W-1.
REQ-018 SHALL make the START->DATA transition when the cycle counter wraps.
REQ-019 SHALL make the DATA->STOP transition when the cycle counter wraps on bit DATA_W-1.
REQ-020 SHALL make the STOP->IDLE transition when the cycle counter wraps.
REQ-021 SHALL, for acceptance at edge k, drive TX low starting after edge k and enter IDLE at edge k+(DATA_W+2)*CLKS_PER_BIT.
REQ-022 SHALL assert DONE for exactly the one cycle following the STOP->IDLE edge; DIN_READY is also high in that cycle.
REQ-023 SHALL, if DIN_VALID is high in that DONE cycle, accept the next word there, giving back-to-back frames with exactly one idle-high TX cycle between the stop bit and the next start bit.
REQ-024 SHALL handle CLKS_PER_BIT=1 and DATA_W=1 without lost or duplicated bits.

Reset
REQ-025 SHALL, while RESET=1 and independent of CLK, force state IDLE, TX=1, DIN_READY=1, BUSY=0, DONE=0, and clear both counters and the shift register.
REQ-026 SHALL, on RESET asserted mid-frame, abort the frame immediately, return TX high, and produce no DONE pulse.
REQ-027 SHALL, after RESET deasserts, accept a word on the first rising edge with DIN_VALID=1.

Verification
REQ-028 SHALL verify the 0xA5 frame with defaults: DIN=0xA5, one-cycle DIN_VALID.
 - TX SHALL produce 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
 - DONE SHALL pulse 40 cycles after acceptance.
REQ-029 SHALL verify the all-zeros and all-ones cases.
 - DIN=0x00 SHALL give TX low for 36 cycles, then high for 4.
 - DIN=0xFF SHALL give TX low for 4 cycles, then high for 36.
REQ-030 SHALL verify back-to-back frames: DIN_VALID held high with 0x3C then 0xC3.
 - Both frames SHALL be sent intact.
 - Exactly one TX=1 idle cycle SHALL separate them.
 - Two DONE pulses SHALL occur, 41 cycles apart.
REQ-031 SHALL verify mid-frame input changes: DIN changed and DIN_VALID pulsed during the DATA state.
 - There SHALL be no acceptance and no corruption.
 - DIN_READY SHALL stay 0 until the DONE cycle.
REQ-032 SHALL verify reset mid-frame: RESET=1 asserted mid-DATA between clock edges.
 - TX=1 and DIN_READY=1 SHALL occur immediately.
 - No DONE SHALL occur.
 - The next frame SHALL transmit correctly.
REQ-033 SHALL verify CLKS_PER_BIT=1, DATA_W=8, DIN=0x81: TX SHALL produce 0,1,0,0,0,0,0,0,1,1 on consecutive cycles, with DONE after 10 cycles.
